// File: rtl/transmitir_serie_param.sv
// Purpose : buffered serial frame transmitter (start, LSB-first data, optional odd parity, stop bits).
// Latency : word written at edge N (idle, FIFO empty) -> busy after N, Rx start bit after N+1.
// Backpr. : full when DEPTH words are stored; a write while full is dropped and pulses overflow.
//
// Ports : CLKOUT (clock), reset_n (async active-low), d_in/enable (write side),
//         full, busy, done, overflow (status), Rx (registered serial line, idles high).
// Macro : TXPS2_PARITY_EN -- when defined, an odd parity bit follows the data bits.
module transmitir_serie_param #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic              CLKOUT,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] d_in,
    input  logic              enable,
    output logic              full,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              Rx
);
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = $clog2(DATA_W);
    localparam int DCW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TXPS2_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full/empty come from the
    // pointer difference alone.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    // Full is judged on the current count, so a same-cycle pop does not
    // rescue a write that arrives while full.
    assign push     = enable & ~full;
    assign overflow = enable & full;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLKOUT or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLKOUT) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= d_in;
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;   // data bit index, reused as stop bit index
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rx_q, rx_d;
    logic              bit_end;
`ifdef TXPS2_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge CLKOUT or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_q      <= 1'b1;
`ifdef TXPS2_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
`ifdef TXPS2_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
`ifdef TXPS2_PARITY_EN
        par_d     = par_q;
`endif
        pop       = 1'b0;
        done      = 1'b0;
        bit_end   = (div_cnt_q == DIV_LAST);

        // Divider free-runs inside a bit and restarts at every bit boundary.
        if (state_q != S_IDLE) begin
            div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                rx_d      = 1'b1;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef TXPS2_PARITY_EN
                    par_d   = ~^head;
`endif
                    rx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    rx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef TXPS2_PARITY_EN
                        state_d   = S_PARITY;
                        rx_d      = par_q;
`else
                        state_d   = S_STOP;
                        rx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        rx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef TXPS2_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    rx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rx_d    = 1'b1;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE) | ~empty;
    assign Rx   = rx_q;

endmodule

// File: tb/tb_transmitir_serie_param.sv
module tb_transmitir_serie_param;

    logic        clk;
    logic        rst_n;
    logic [2:0]  en;
    logic [10:0] din;
    logic [2:0]  full_w, busy_w, done_w, ovf_w, rx_w;

`ifdef TXPS2_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // u0: 8 bits, DIV 4, 1 stop; u1: 8 bits, DIV 2, 2 stops; u2: 11 bits, DIV 1
    transmitir_serie_param #(.DATA_W(8), .DIV(4), .DEPTH(4), .STOP_BITS(1)) u0 (
        .CLKOUT(clk), .reset_n(rst_n), .d_in(din[7:0]), .enable(en[0]),
        .full(full_w[0]), .busy(busy_w[0]), .done(done_w[0]), .overflow(ovf_w[0]), .Rx(rx_w[0]));
    transmitir_serie_param #(.DATA_W(8), .DIV(2), .DEPTH(4), .STOP_BITS(2)) u1 (
        .CLKOUT(clk), .reset_n(rst_n), .d_in(din[7:0]), .enable(en[1]),
        .full(full_w[1]), .busy(busy_w[1]), .done(done_w[1]), .overflow(ovf_w[1]), .Rx(rx_w[1]));
    transmitir_serie_param #(.DATA_W(11), .DIV(1), .DEPTH(4), .STOP_BITS(1)) u2 (
        .CLKOUT(clk), .reset_n(rst_n), .d_in(din), .enable(en[2]),
        .full(full_w[2]), .busy(busy_w[2]), .done(done_w[2]), .overflow(ovf_w[2]), .Rx(rx_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // seq holds the serial bits in transmit order, first bit leftmost
    typedef struct {
        int          dut;
        logic [10:0] word;
        int          div;
        int          nbits;
        logic [15:0] seq;
    } vec_t;

    vec_t vecs [6];

    localparam int TL = 300;
    logic tr_rx   [TL];
    logic tr_done [TL];
    logic tr_busy [TL];
    logic tr_full [TL];

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input int nwrong, input int first);
        total++;
        if (nwrong != 0) begin
            bad++;
            $display("FAIL %s: %0d cycles wrong, first at cycle %0d, want 0 wrong", name, nwrong, first);
        end
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int   d, ncyc, nb_rx, nb_dn, f_rx, f_dn;
        logic exp_rx;
        v = vecs[idx];
        d = v.dut;
        ncyc = v.nbits * v.div;
        nb_rx = 0; nb_dn = 0; f_rx = -1; f_dn = -1;
        @(negedge clk);
        din   = v.word;
        en[d] = 1'b1;
        @(negedge clk);
        en[d] = 1'b0;
        chk($sformatf("v%0d_busy_rise", idx), busy_w[d], 1'b1);
        chk($sformatf("v%0d_rx_before_start", idx), rx_w[d], 1'b1);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            exp_rx = v.seq[v.nbits - 1 - k / v.div];
            if (rx_w[d] !== exp_rx) begin
                if (f_rx < 0) f_rx = k;
                nb_rx++;
            end
            if (done_w[d] !== (k == ncyc - 1)) begin
                if (f_dn < 0) f_dn = k;
                nb_dn++;
            end
        end
        chk_cnt($sformatf("v%0d_rx_frame", idx), nb_rx, f_rx);
        chk_cnt($sformatf("v%0d_done_pos", idx), nb_dn, f_dn);
        @(negedge clk);
        chk($sformatf("v%0d_rx_idle_after", idx), rx_w[d], 1'b1);
        chk($sformatf("v%0d_done_after", idx), done_w[d], 1'b0);
        chk($sformatf("v%0d_busy_fall", idx), busy_w[d], 1'b0);
    endtask

    initial begin
`ifdef TXPS2_PARITY_EN
        vecs[0] = '{0, 11'h00C, 4, 11, 16'b00011000011};
        vecs[1] = '{0, 11'h0A5, 4, 11, 16'b01010010111};
        vecs[2] = '{1, 11'h0FF, 2, 12, 16'b011111111111};
        vecs[3] = '{1, 11'h080, 2, 12, 16'b000000001011};
        vecs[4] = '{2, 11'h5A3, 1, 14, 16'b01100010110111};
        vecs[5] = '{2, 11'h001, 1, 14, 16'b01000000000001};
`else
        vecs[0] = '{0, 11'h00C, 4, 10, 16'b0001100001};
        vecs[1] = '{0, 11'h0A5, 4, 10, 16'b0101001011};
        vecs[2] = '{1, 11'h0FF, 2, 11, 16'b01111111111};
        vecs[3] = '{1, 11'h080, 2, 11, 16'b00000000111};
        vecs[4] = '{2, 11'h5A3, 1, 13, 16'b0110001011011};
        vecs[5] = '{2, 11'h001, 1, 13, 16'b0100000000001};
`endif
        rst_n = 1'b0;
        en    = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_rx%0d", d),   rx_w[d],   1'b1);
            chk($sformatf("rst_full%0d", d), full_w[d], 1'b0);
            chk($sformatf("rst_busy%0d", d), busy_w[d], 1'b0);
            chk($sformatf("rst_done%0d", d), done_w[d], 1'b0);
            chk($sformatf("rst_ovf%0d", d),  ovf_w[d],  1'b0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frames on each configuration
        for (int i = 0; i < 6; i++) run_frame(i);
        repeat (2) @(negedge clk);

        // fill and overflow: words 1..6 on consecutive cycles into u0
        begin
            int F, st, o, b, nrx, ndn, nbs, nfl, frx, fdn, fbs, ffl, busy_end;
            logic [7:0] w;
            logic er, ed, eb, ef;
            F = vecs[0].nbits * 4;
            fork
                begin
                    for (int i = 0; i < 6; i++) begin
                        @(negedge clk);
                        din   = 11'(i + 1);
                        en[0] = 1'b1;
                        #1;
                        chk($sformatf("fill_ovf%0d", i), ovf_w[0], (i == 5));
                    end
                    @(negedge clk);
                    en[0] = 1'b0;
                    #1;
                    chk("fill_ovf_clear", ovf_w[0], 1'b0);
                end
                begin
                    for (int j = 0; j < TL; j++) begin
                        @(negedge clk);
                        tr_rx[j]   = rx_w[0];
                        tr_done[j] = done_w[0];
                        tr_busy[j] = busy_w[0];
                        tr_full[j] = full_w[0];
                    end
                end
            join
            nrx = 0; ndn = 0; nbs = 0; nfl = 0;
            frx = -1; fdn = -1; fbs = -1; ffl = -1;
            busy_end = 2 + 4 * (F + 1) + F;
            for (int j = 0; j < TL; j++) begin
                er = 1'b1;
                ed = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    st = 2 + k * (F + 1);
                    if (j >= st && j < st + F) begin
                        o = j - st;
                        b = o / 4;
                        w = 8'(k + 1);
                        if (b == 0)                  er = 1'b0;
                        else if (b <= 8)             er = w[b - 1];
                        else if (PAR == 1 && b == 9) er = ~^w;
                        else                         er = 1'b1;
                        ed = (o == F - 1);
                    end
                end
                eb = (j >= 1 && j < busy_end);
                ef = (j >= 5 && j < 3 + F);
                if (tr_rx[j]   !== er) begin nrx++; if (frx < 0) frx = j; end
                if (tr_done[j] !== ed) begin ndn++; if (fdn < 0) fdn = j; end
                if (tr_busy[j] !== eb) begin nbs++; if (fbs < 0) fbs = j; end
                if (tr_full[j] !== ef) begin nfl++; if (ffl < 0) ffl = j; end
            end
            chk_cnt("fill_rx_frames", nrx, frx);
            chk_cnt("fill_done_pulses", ndn, fdn);
            chk_cnt("fill_busy", nbs, fbs);
            chk_cnt("fill_full", nfl, ffl);
        end

        // reset in the middle of frame 0x55 with two more words queued
        begin
            int nrx, ndn, nbs, frx, fdn, fbs;
            @(negedge clk); din = 11'h055; en[0] = 1'b1;
            @(negedge clk); din = 11'h011;
            @(negedge clk); din = 11'h022;
            @(negedge clk); en[0] = 1'b0;
            repeat (9) @(negedge clk);
            chk("mid_busy_before_rst", busy_w[0], 1'b1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_rx",   rx_w[0],   1'b1);
            chk("mid_rst_busy", busy_w[0], 1'b0);
            chk("mid_rst_done", done_w[0], 1'b0);
            chk("mid_rst_full", full_w[0], 1'b0);
            repeat (2) @(negedge clk);
            chk("mid_rst_done_held", done_w[0], 1'b0);
            rst_n = 1'b1;
            nrx = 0; ndn = 0; nbs = 0; frx = -1; fdn = -1; fbs = -1;
            for (int j = 0; j < 100; j++) begin
                @(negedge clk);
                if (rx_w[0]   !== 1'b1) begin nrx++; if (frx < 0) frx = j; end
                if (done_w[0] !== 1'b0) begin ndn++; if (fdn < 0) fdn = j; end
                if (busy_w[0] !== 1'b0) begin nbs++; if (fbs < 0) fbs = j; end
            end
            chk_cnt("post_rst_rx_idle", nrx, frx);
            chk_cnt("post_rst_no_done", ndn, fdn);
            chk_cnt("post_rst_not_busy", nbs, fbs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
